rgb_button_fsm: RTL and testbench
=================================

// Module: rgb_button_fsm
// PURPOSE
//   Parametrised button-driven colour selector for the VGA colour path. Debounces five push
//   buttons (U/D/L/R/C). L/R select the active channel; U/D step its intensity up/down;
//   C locks or unlocks the panel.
//   Drives a packed RGB word that feeds the pixel generator directly, on the pixel clock domain.
// PARAMETERS
//   R_W              3        red channel width (bits)
//   G_W              3        green channel width (bits)
//   B_W              2        blue channel width (bits); default packs 3-3-2 into 8 bits
//   DEBOUNCE_CYCLES  250000   consecutive stable samples required to accept a level change (>=2)
//   REPEAT_DELAY     25000000 hold time before auto-repeat starts (used only with AUTO_REPEAT_EN)
//   REPEAT_PERIOD    5000000  cycles between repeated steps (used only with AUTO_REPEAT_EN)
// PORTS
//   clk     in   1              system/pixel clock
//   rst_n   in   1              asynchronous active-low reset
//   B_U     in   1              raw button: increment the active channel
//   B_D     in   1              raw button: decrement the active channel
//   B_L     in   1              raw button: select the previous channel
//   B_R     in   1              raw button: select the next channel
//   B_C     in   1              raw button: lock/unlock toggle
//   rgb     out  R_W+G_W+B_W    packed {R,G,B}, registered
//   sel     out  2              active channel: 0=R, 1=G, 2=B
//   locked  out  1              1 while in LOCK state
// BEHAVIOUR
//   Reset (async assert, sync release): rgb=0, sel=0, locked=0, state=SEL_R, debounce
//     counters=0, debounced levels=0, no events pending.
//   Input path per button: 2-FF synchroniser -> debouncer -> rising-edge detector.
//     Debounced level flips only after DEBOUNCE_CYCLES consecutive synced samples differ from it.
//     Any glitch restarts the count. A press event is a 1-cycle pulse on the debounced rise.
//   Latency: raw press stable from cycle 0 -> rgb/sel/locked update at cycle DEBOUNCE_CYCLES+3.
//   FSM states: SEL_R, SEL_G, SEL_B, LOCK. sel holds the last channel while in LOCK.
//     R event: SEL_R->SEL_G->SEL_B->SEL_R (wraps).
//     L event: SEL_R->SEL_B->SEL_G->SEL_R (wraps).
//     C event in SEL_x: go to LOCK. C event in LOCK: return to SEL_[sel].
//     LOCK ignores U/D/L/R events.
//   Arithmetic: U adds 1 and D subtracts 1 on the selected field only. Fields saturate at 0 and
//     at 2^W-1 and never wrap. Other fields are unchanged.
//   Simultaneous events in one cycle: priority C > L/R > U/D; only the highest class acts.
//     L+R together: no channel change. U+D together: no intensity change.
//   Held buttons generate exactly one event (without the option).
//   Mid-operation reset: all state clears immediately. A button still held at release does not
//     generate an event until the debouncer has seen it stable for DEBOUNCE_CYCLES.
// CONFIGURATION
//   AUTO_REPEAT_EN defined: while the debounced U or D level is held (not LOCK), one extra step
//     occurs REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD cycles.
//     Saturation still applies. Release, a C/L/R event, or LOCK stops and clears the repeat timer.
//   AUTO_REPEAT_EN undefined: no repeat logic is generated; REPEAT_* parameters are unused.
// STRUCTURE
//   Package rgb_fsm_pkg:
//     state localparams ST_SEL_R=0, ST_SEL_G=1, ST_SEL_B=2, ST_LOCK=3
//     channel codes CH_R/CH_G/CH_B
//     btn index constants BTN_U..BTN_C
//   Sub-module btn_debounce (param CYCLES):
//     ports clk, rst_n, raw_i, level_o, press_o (synchroniser + counter + edge detect)
//     instantiated 5x
//   Top: FSM, saturating field update, output packing (and repeat timer when enabled).
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, default widths)
//   1. Reset then idle 50 cycles -> rgb=8'h00, sel=0, locked=0.
//   2. Press B_U 3 times, each held 10 cycles -> rgb=8'b011_000_00.
//      Then B_R, then B_U x2 -> sel=1, rgb=8'b011_010_00.
//   3. 1-3 cycle glitch pulses on B_U (< DEBOUNCE_CYCLES) -> rgb unchanged.
//      Stable press -> update exactly DEBOUNCE_CYCLES+3 cycles after the edge.
//   4. Blue selected (B_L from SEL_R), B_U x5 -> blue=2'b11 (saturates at 3).
//      B_D x5 -> blue=0, no wrap.
//   5. B_C -> locked=1, sel kept. B_U/B_R ignored, rgb stable. B_C again -> locked=0, same sel.
//      B_C and B_U pressed in the same cycle -> lock only.
//   6. AUTO_REPEAT_EN: on red, hold B_U 40 cycles past its event -> steps at +0, +20, +25, +30,
//      +35 -> red=5. Without the macro, same stimulus -> red=1.
//   7. Assert rst_n low while B_U held mid-debounce -> immediate all-zero outputs.
//      No event until DEBOUNCE_CYCLES stable samples after release of reset.

Source files
------------

// File: rtl/rgb_fsm_pkg.sv
// Shared constants for the button-driven RGB selector: FSM state codes, channel codes, button indices.
// No logic; state codes for the SEL states equal the channel codes so a channel maps straight to its state.
package rgb_fsm_pkg;

    localparam logic [1:0] ST_SEL_R = 2'd0;
    localparam logic [1:0] ST_SEL_G = 2'd1;
    localparam logic [1:0] ST_SEL_B = 2'd2;
    localparam logic [1:0] ST_LOCK  = 2'd3;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam int BTN_U   = 0;
    localparam int BTN_D   = 1;
    localparam int BTN_L   = 2;
    localparam int BTN_R   = 3;
    localparam int BTN_C   = 4;
    localparam int NUM_BTN = 5;

endpackage

// File: rtl/btn_debounce.sv
// Button input path: 2-FF synchroniser, stable-count debouncer, registered rising-edge pulse.
// Latency: press_o pulses CYCLES+2 clocks after the first edge that samples a stable raw level.
// No backpressure: free-running, one pulse per accepted rise.
module btn_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_dly_q, press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            // Level flips on the CYCLES-th consecutive differing sample; any agreeing sample restarts.
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/rgb_button_fsm.sv
// Five-button colour selector driving a packed {R,G,B} word; optional auto-repeat under AUTO_REPEAT_EN.
// Latency: outputs update DEBOUNCE_CYCLES+3 clocks after a raw press is first sampled.
// No backpressure: events act in the cycle they arrive, priority C > L/R > U/D.
module rgb_button_fsm
    import rgb_fsm_pkg::*;
#(
    parameter int R_W             = 3,
    parameter int G_W             = 3,
    parameter int B_W             = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     B_U,
    input  logic                     B_D,
    input  logic                     B_L,
    input  logic                     B_R,
    input  logic                     B_C,
    output logic [R_W+G_W+B_W-1:0]   rgb,
    output logic [1:0]               sel,
    output logic                     locked
);

    logic               rst_s1_q, rst_s2_q;
    logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_ev;
    logic               ev_u, ev_d, ev_l, ev_r, ev_c;
    logic               rpt_up, rpt_dn, step_up, step_dn;
    logic [1:0]         state_q, state_d, sel_q, sel_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [G_W-1:0]     g_q, g_d;
    logic [B_W-1:0]     b_q, b_d;
    logic               unused_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_s1_q <= 1'b0;
            rst_s2_q <= 1'b0;
        end else begin
            rst_s1_q <= 1'b1;
            rst_s2_q <= rst_s1_q;
        end
    end

    assign btn_raw = {B_C, B_R, B_L, B_D, B_U};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst_n   (rst_s2_q),
            .raw_i   (btn_raw[i]),
            .level_o (btn_lvl[i]),
            .press_o (btn_ev[i])
        );
    end

    assign ev_u = btn_ev[BTN_U];
    assign ev_d = btn_ev[BTN_D];
    assign ev_l = btn_ev[BTN_L];
    assign ev_r = btn_ev[BTN_R];
    assign ev_c = btn_ev[BTN_C];

`ifdef AUTO_REPEAT_EN
    logic        rpt_act_q, rpt_dir_up_q, rpt_first_q, rpt_held, rpt_fire;
    logic [31:0] rpt_cnt_q;

    assign rpt_held = rpt_dir_up_q ? btn_lvl[BTN_U] : btn_lvl[BTN_D];
    assign rpt_fire = rpt_act_q && rpt_held && (state_q != ST_LOCK) &&
                      (rpt_cnt_q == (rpt_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD)));
    assign rpt_up   = rpt_fire & rpt_dir_up_q;
    assign rpt_dn   = rpt_fire & ~rpt_dir_up_q;

    always_ff @(posedge clk or negedge rst_s2_q) begin
        if (!rst_s2_q) begin
            rpt_act_q    <= 1'b0;
            rpt_dir_up_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_cnt_q    <= '0;
        end else if (ev_c || ev_l || ev_r || (state_q == ST_LOCK) || (ev_u && ev_d)) begin
            rpt_act_q <= 1'b0;
            rpt_cnt_q <= '0;
        end else if (ev_u || ev_d) begin
            rpt_act_q    <= 1'b1;
            rpt_dir_up_q <= ev_u;
            rpt_first_q  <= 1'b1;
            rpt_cnt_q    <= 32'd1;
        end else if (rpt_act_q && !rpt_held) begin
            rpt_act_q <= 1'b0;
            rpt_cnt_q <= '0;
        end else if (rpt_fire) begin
            rpt_first_q <= 1'b0;
            rpt_cnt_q   <= 32'd1;
        end else if (rpt_act_q) begin
            rpt_cnt_q <= rpt_cnt_q + 32'd1;
        end
    end

    assign unused_lvl = ^btn_lvl[NUM_BTN-1:BTN_L];
`else
    assign rpt_up     = 1'b0;
    assign rpt_dn     = 1'b0;
    assign unused_lvl = ^{btn_lvl, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (ev_c) begin
            state_d = (state_q == ST_LOCK) ? sel_q : ST_LOCK;
        end else if (state_q != ST_LOCK) begin
            if (ev_l || ev_r) begin
                if (ev_r && !ev_l) begin
                    case (sel_q)
                        CH_R:    sel_d = CH_G;
                        CH_G:    sel_d = CH_B;
                        default: sel_d = CH_R;
                    endcase
                end else if (ev_l && !ev_r) begin
                    case (sel_q)
                        CH_R:    sel_d = CH_B;
                        CH_B:    sel_d = CH_G;
                        default: sel_d = CH_R;
                    endcase
                end
                state_d = sel_d;
            end else begin
                step_up = (ev_u & ~ev_d) | rpt_up;
                step_dn = (ev_d & ~ev_u) | rpt_dn;
            end
        end
    end

    always_comb begin
        r_d = r_q;
        g_d = g_q;
        b_d = b_q;
        case (sel_q)
            CH_R: begin
                if (step_up && r_q != {R_W{1'b1}}) r_d = r_q + 1'b1;
                if (step_dn && r_q != '0)          r_d = r_q - 1'b1;
            end
            CH_G: begin
                if (step_up && g_q != {G_W{1'b1}}) g_d = g_q + 1'b1;
                if (step_dn && g_q != '0)          g_d = g_q - 1'b1;
            end
            CH_B: begin
                if (step_up && b_q != {B_W{1'b1}}) b_d = b_q + 1'b1;
                if (step_dn && b_q != '0)          b_d = b_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_s2_q) begin
        if (!rst_s2_q) begin
            state_q <= ST_SEL_R;
            sel_q   <= CH_R;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign rgb    = {r_q, g_q, b_q};
    assign sel    = sel_q;
    assign locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_rgb_button_fsm.sv
module tb_rgb_button_fsm;

    localparam int DB = 4;
    localparam logic [4:0] MU = 5'b00001;
    localparam logic [4:0] MD = 5'b00010;
    localparam logic [4:0] ML = 5'b00100;
    localparam logic [4:0] MR = 5'b01000;
    localparam logic [4:0] MC = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       B_U = 1'b0, B_D = 1'b0, B_L = 1'b0, B_R = 1'b0, B_C = 1'b0;
    logic [7:0] rgb;
    logic [1:0] sel;
    logic       locked;

    always #5 clk = ~clk;

    rgb_button_fsm #(
        .R_W(3), .G_W(3), .B_W(2),
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .B_U(B_U), .B_D(B_D), .B_L(B_L), .B_R(B_R), .B_C(B_C),
        .rgb(rgb), .sel(sel), .locked(locked)
    );

    typedef struct {
        logic [4:0] btn;
        logic [7:0] rgb;
        logic [1:0] sel;
        logic       lock;
    } vec_t;

    vec_t vecs[28];
    vec_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_btn(input logic [4:0] m);
        {B_C, B_R, B_L, B_D, B_U} = m;
    endtask

    task automatic press(input logic [4:0] m, input int hold);
        @(negedge clk);
        drive_btn(m);
        repeat (hold) @(negedge clk);
        drive_btn(5'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic setv(input int i, input logic [4:0] m, input logic [7:0] c,
                        input logic [1:0] s, input logic l);
        vecs[i].btn  = m;
        vecs[i].rgb  = c;
        vecs[i].sel  = s;
        vecs[i].lock = l;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t e;
        int   got;
        int   n;
        logic [2:0] red_mid, red_end;
`ifdef AUTO_REPEAT_EN
        red_mid = 3'd2;
        red_end = 3'd5;
`else
        red_mid = 3'd1;
        red_end = 3'd1;
`endif
        setv(0,  MU, 8'h20, 2'd0, 1'b0);
        setv(1,  MU, 8'h40, 2'd0, 1'b0);
        setv(2,  MU, 8'h60, 2'd0, 1'b0);
        setv(3,  MR, 8'h60, 2'd1, 1'b0);
        setv(4,  MU, 8'h64, 2'd1, 1'b0);
        setv(5,  MU, 8'h68, 2'd1, 1'b0);
        setv(6,  ML, 8'h68, 2'd0, 1'b0);
        setv(7,  ML, 8'h68, 2'd2, 1'b0);
        setv(8,  MU, 8'h69, 2'd2, 1'b0);
        setv(9,  MU, 8'h6A, 2'd2, 1'b0);
        setv(10, MU, 8'h6B, 2'd2, 1'b0);
        setv(11, MU, 8'h6B, 2'd2, 1'b0);
        setv(12, MU, 8'h6B, 2'd2, 1'b0);
        setv(13, MD, 8'h6A, 2'd2, 1'b0);
        setv(14, MD, 8'h69, 2'd2, 1'b0);
        setv(15, MD, 8'h68, 2'd2, 1'b0);
        setv(16, MD, 8'h68, 2'd2, 1'b0);
        setv(17, MD, 8'h68, 2'd2, 1'b0);
        setv(18, MC, 8'h68, 2'd2, 1'b1);
        setv(19, MU, 8'h68, 2'd2, 1'b1);
        setv(20, MR, 8'h68, 2'd2, 1'b1);
        setv(21, MC, 8'h68, 2'd2, 1'b0);
        setv(22, MC | MU, 8'h68, 2'd2, 1'b1);
        setv(23, MC, 8'h68, 2'd2, 1'b0);
        setv(24, MR, 8'h68, 2'd0, 1'b0);
        setv(25, ML | MR, 8'h68, 2'd0, 1'b0);
        setv(26, MU | MD, 8'h68, 2'd0, 1'b0);
        setv(27, MD, 8'h48, 2'd0, 1'b0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'h00);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);

        for (int i = 0; i < 28; i++) begin
            sb_q.push_back(vecs[i]);
            press(vecs[i].btn, 10);
            e = sb_q.pop_front();
            check($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(e.rgb));
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(e.sel));
            check($sformatf("vec%0d_locked", i), 32'(locked), 32'(e.lock));
        end

        for (int g = 1; g <= 3; g++) begin
            @(negedge clk);
            B_U = 1'b1;
            repeat (g) @(negedge clk);
            B_U = 1'b0;
            repeat (12) @(negedge clk);
            check($sformatf("glitch%0d_rgb", g), 32'(rgb), 32'h48);
        end

        @(negedge clk);
        B_U = 1'b1;
        for (int k = 0; k <= DB + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == DB + 2) check("latency_before", 32'(rgb), 32'h48);
            if (k == DB + 3) check("latency_at", 32'(rgb), 32'h68);
        end
        repeat (3) @(negedge clk);
        B_U = 1'b0;
        repeat (12) @(negedge clk);

        rst_n = 1'b0;
        #1;
        check("rst1_rgb", 32'(rgb), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst1_after_rgb", 32'(rgb), 32'h00);

        B_U = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge clk);
            if (rgb != 8'h00) got = 1;
        end
        check("ar_first_event", 32'(got), 32'd1);
        repeat (22) @(negedge clk);
        check("ar_mid_red", 32'(rgb[7:5]), 32'(red_mid));
        repeat (8) @(negedge clk);
        B_U = 1'b0;
        repeat (15) @(negedge clk);
        check("ar_end_rgb", 32'(rgb), 32'({red_end, 5'b0}));

        B_U = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_rgb", 32'(rgb), 32'h00);
        check("rst2_sel", 32'(sel), 32'd0);
        check("rst2_locked", 32'(locked), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rgb != 8'h00 && n < 0) n = k;
        end
        check("rst2_no_early_event", 32'(n >= DB + 3), 32'd1);
        check("rst2_event_seen", 32'(n >= 0 && n <= DB + 6), 32'd1);
        check("rst2_final_rgb", 32'(rgb), 32'h20);
        B_U = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
